systolic_matmul_engine: RTL

//  Self-sequencing, weight-stationary NxN systolic matrix-multiply engine: C = A x B for a runtime size n <= N.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_pe.sv | 33 +++
 rtl/systolic_matmul_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  // Smallest accumulator that cannot overflow for the default 4x4, 16-bit configuration.
  localparam int ACC_MIN_W = 2 * 16 + 2;

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: holds a weight, passes activations right and partial sums down.
module systolic_pe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic signed [WIDTH-1:0]     a_in,
  input  logic signed [ACC_WIDTH-1:0] psum_in,
  input  logic signed [WIDTH-1:0]     w,
  output logic signed [WIDTH-1:0]     a_out,
  output logic signed [ACC_WIDTH-1:0] psum_out
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = (2*WIDTH)'(a_in) * (2*WIDTH)'(w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out    <= '0;
      psum_out <= '0;
    end else if (clr) begin
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      a_out    <= a_in;
      psum_out <= psum_in + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// Self-sequencing NxN systolic matmul: loads B (weights) and A, streams skewed A rows, writes saturated C.
// Memory handshake: mem_addr with mem_we=0 returns mem_rdata one cycle later; mem_we=1 writes mem_wdata.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ADDR_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(N+1)-1:0]   n,
  input  logic [ADDR_W-1:0]        addr_A,
  input  logic [ADDR_W-1:0]        addr_B,
  input  logic [ADDR_W-1:0]        addr_C,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag,
  output state_t                   fsm_state
);

  localparam int NW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N * N + 3 * N) + 1;

  state_t state, state_next;
  logic [NW-1:0] n_q, n_in;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic [CW-1:0] cnt;
  logic [IW-1:0] row_i, col_i;
  int nn, cnt_i;
  logic load_cap, step_idx, clamp, clr_pe;
  logic signed [63:0] r_ext, r_sat;

  logic signed [WIDTH-1:0]     w_buf [N][N];
  logic signed [WIDTH-1:0]     a_buf [N][N];
  logic signed [ACC_WIDTH-1:0] r_buf [N][N];
  logic signed [WIDTH-1:0]     act   [N][N+1];
  logic signed [ACC_WIDTH-1:0] psum  [N+1][N];
  logic signed [WIDTH-1:0]     row_a [N];
  logic [IW-1:0]               cap_row [N];
  logic [N-1:0]                cap_en;
  logic [N-1:0]                unused_a;

  assign n_in     = (int'(n) > N) ? NW'(N) : n;
  assign nn       = int'(n_q) * int'(n_q);
  assign cnt_i    = int'(cnt);
  assign load_cap = ((state == S_LOAD_W) || (state == S_LOAD_A)) && (cnt != '0);
  assign step_idx = load_cap || (state == S_WRITE);
  assign clr_pe   = (state == S_LOAD_A);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = (n_in == '0) ? S_DONE : S_LOAD_W;
      S_LOAD_W:  if (cnt_i == nn) state_next = S_LOAD_A;
      S_LOAD_A:  if (cnt_i == nn) state_next = S_COMPUTE;
      S_COMPUTE: if (cnt_i == 2 * int'(n_q) + N - 2) state_next = S_WRITE;
      S_WRITE:   if (cnt_i == nn - 1) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    r_ext     = 64'(r_buf[row_i][col_i]);
    r_sat     = sat_to_width(r_ext, WIDTH);
    clamp     = (state == S_WRITE) && (r_sat != r_ext);
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_LOAD_W: if (cnt_i < nn) mem_addr = base_b + ADDR_W'(cnt);
      S_LOAD_A: if (cnt_i < nn) mem_addr = base_a + ADDR_W'(cnt);
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_c + ADDR_W'(cnt);
        mem_wdata = r_sat[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // cnt counts cycles within a state; row_i/col_i walk the current element in row-major order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      row_i    <= '0;
      col_i    <= '0;
      n_q      <= '0;
      base_a   <= '0;
      base_b   <= '0;
      base_c   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (state_next != state) begin
        cnt   <= '0;
        row_i <= '0;
        col_i <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (step_idx) begin
          if (int'(col_i) == int'(n_q) - 1) begin
            col_i <= '0;
            row_i <= row_i + 1'b1;
          end else begin
            col_i <= col_i + 1'b1;
          end
        end
      end
      if ((state == S_IDLE) && start) begin
        n_q      <= n_in;
        base_a   <= addr_A;
        base_b   <= addr_B;
        base_c   <= addr_C;
        sat_flag <= 1'b0;
      end else if (clamp) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Skew into the array's left edge; deskew from its bottom edge.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      row_a[r] = '0;
      if ((state == S_COMPUTE) && (cnt_i - r >= 0) && (cnt_i - r < int'(n_q)))
        row_a[r] = a_buf[IW'(cnt_i - r)][r];
    end
    for (int c = 0; c < N; c++) begin
      cap_en[c]  = 1'b0;
      cap_row[c] = '0;
      if ((state == S_COMPUTE) && (c < int'(n_q)) && (cnt_i - c - N >= 0) &&
          (cnt_i - c - N < int'(n_q))) begin
        cap_en[c]  = 1'b1;
        cap_row[c] = IW'(cnt_i - c - N);
      end
    end
  end

  // Buffers are cleared on job accept so rows/columns beyond n contribute zero.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          w_buf[r][c] <= '0;
          a_buf[r][c] <= '0;
        end
    end
    if (load_cap && (state == S_LOAD_W)) w_buf[row_i][col_i] <= mem_rdata;
    if (load_cap && (state == S_LOAD_A)) a_buf[row_i][col_i] <= mem_rdata;
    for (int c = 0; c < N; c++)
      if (cap_en[c]) r_buf[cap_row[c]][c] <= psum[N][c];
  end

  genvar gr, gc;
  for (gc = 0; gc < N; gc++) begin : g_top
    assign psum[0][gc] = '0;
  end
  for (gr = 0; gr < N; gr++) begin : g_row
    assign act[gr][0]   = row_a[gr];
    assign unused_a[gr] = ^act[gr][N];
    for (gc = 0; gc < N; gc++) begin : g_col
      systolic_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_pe),
        .a_in     (act[gr][gc]),
        .psum_in  (psum[gr][gc]),
        .w        (w_buf[gr][gc]),
        .a_out    (act[gr][gc+1]),
        .psum_out (psum[gr+1][gc])
      );
    end
  end

endmodule
